axi_rd_arbiter: RTL and testbench
=================================

Name: axi_rd_arbiter

Overview:
- Read-address-channel arbiter in front of the AXI address decoder.
- Shares one AR path among NUM_M masters: CPU instruction port, CPU data port, DMA.
- Grants round-robin, one outstanding read transaction at a time.
- Muxes the winner's address/len onto the decoder input and holds the grant until the last R beat of that burst completes.

Parameters:
- NUM_M, 3, number of requesting masters.
- IDX_W, 2, width of the grant index; must be at least clog2(NUM_M).
- ADDR_W, 32, address width; equals AXI_ADDR_BITS.
- LEN_W, 4, burst length field width.
- TIMEOUT_CYC, 1024, R-phase watchdog limit in cycles; used only with the optional feature.

Ports:
- ACLK  in  1  clock.
- ARESETn  in  1  reset, asynchronous, active-low.
- arvalid_m_i  in  NUM_M  per-master ARVALID.
- araddr_m_i  in  NUM_M*ADDR_W  per-master ARADDR, packed; master k at bits [k*ADDR_W +: ADDR_W].
- arlen_m_i  in  NUM_M*LEN_W  per-master ARLEN, packed.
- arready_m_o  out  NUM_M  per-master ARREADY.
- arvalid_o  out  1  ARVALID to decoder validm_i.
- araddr_o  out  ADDR_W  ARADDR to decoder addr_i.
- arlen_o  out  LEN_W  granted ARLEN.
- arready_i  in  1  ARREADY from decoder readys_o.
- rvalid_i  in  1  R channel valid of the active transaction.
- rready_i  in  1  R channel ready of the active transaction.
- rlast_i  in  1  R channel last.
- grant_o  out  NUM_M  one-hot grant; 0 when IDLE.
- grant_idx_o  out  IDX_W  index of the granted master.
- busy_o  out  1  high in ADDR or DATA.
- timeout_o  out  1  watchdog pulse; present only with the optional feature.

Behaviour:
- States: IDLE, ADDR, DATA; state register is 2 bits.
- Reset (async, any state):
  - state=IDLE; grant_o=0; grant_idx_o=0; busy_o=0.
  - Round-robin pointer last=NUM_M-1, so master 0 has top priority after reset.
  - Counters cleared.
- Combinational outputs:
  - arvalid_o = arvalid_m_i[grant_idx_o] in ADDR, else 0.
  - araddr_o and arlen_o select the granted master in ADDR/DATA; 0 in IDLE.
  - arready_m_o[k] = arready_i & (state==ADDR) & (k==grant_idx_o); all other bits 0.
- IDLE:
  - If any arvalid_m_i is set, pick the first requester searching from last+1 cyclically with wrap NUM_M-1 -> 0.
  - Register grant_idx_o and grant_o, go to ADDR.
  - Latency: request at cycle n -> arvalid_o at cycle n+1.
- ADDR:
  - On arvalid_o & arready_i: go to DATA, last <= grant_idx_o.
  - New requests from other masters are ignored; the grant does not change.
  - If the granted master drops arvalid (AXI violation), remain in ADDR and keep the grant.
- DATA:
  - Leave only on rvalid_i & rready_i & rlast_i -> IDLE; grant_o clears the next cycle.
  - Non-last beats and stalled beats (rvalid & ~rready) keep DATA.
  - arready_m_o is all zero.
- R beats seen in IDLE or ADDR are ignored.
- Back-to-back: IDLE re-arbitrates on the cycle after returning, so there is one dead cycle between transactions.
- NUM_M=1 degenerates to a pass-through with the same FSM timing.

Optional Feature:
- Macro: AXI_RD_ARB_TIMEOUT_EN.
- Defined:
  - A 16-bit cycle counter clears on entry to DATA and increments each DATA cycle without a last handshake.
  - When it reaches TIMEOUT_CYC-1: timeout_o pulses high for 1 cycle, FSM forces IDLE, last <= grant_idx_o.
  - Any later R beats from the abandoned burst are ignored.
- Not defined: timeout_o port and counter absent; DATA waits indefinitely.

Test Plan:
- Single request: after reset, M1 raises arvalid with addr=0x0001_0040, len=0 -> grant_o=3'b010 and arvalid_o=1 with araddr_o=0x0001_0040 one cycle later. With arready_i=1, arready_m_o=3'b010 for 1 cycle. One R beat with rlast -> IDLE and busy_o=0 the next cycle.
- Fairness: M0, M1, M2 all hold arvalid continuously, each burst len=0 -> grant order 0,1,2,0,1,2. One idle cycle between grants.
- Burst lock: M0 len=3 granted; M2 requests during DATA -> M2 not granted during the 4 beats (including an rready=0 stall on beat 2). M2 is granted the cycle after the rlast handshake.
- Decoder backpressure: arready_i=0 for 5 cycles in ADDR -> arvalid_o stays 1, address stays stable, grant unchanged, arready_m_o=0. Handshake on cycle 6.
- Reset mid-burst: assert ARESETn=0 in DATA -> grant_o=0, busy_o=0 immediately. After release, simultaneous M1 and M2 requests -> M1 wins.
- Timeout (with AXI_RD_ARB_TIMEOUT_EN, TIMEOUT_CYC=16): no R beats after the handshake -> timeout_o high exactly at DATA cycle 16, FSM back to IDLE. The next arbitration starts after the timed-out master.

Source files
------------

// File: rtl/axi_rd_arbiter.sv
// axi_rd_arbiter
// Round-robin arbiter for the AXI read-address channel. One master at a time
// owns the AR path and keeps the grant until the last R beat of its burst
// has been handshaked. The FSM has three states: IDLE, ADDR and DATA.
// Optional feature: define AXI_RD_ARB_TIMEOUT_EN to add an R-phase watchdog
// (TIMEOUT_CYC cycles) and the timeout_o pulse output.
module axi_rd_arbiter #(
  parameter int NUM_M       = 3,
  parameter int IDX_W       = 2,
  parameter int ADDR_W      = 32,
  parameter int LEN_W       = 4,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                    ACLK,
  input  logic                    ARESETn,
  input  logic [NUM_M-1:0]        arvalid_m_i,
  input  logic [NUM_M*ADDR_W-1:0] araddr_m_i,
  input  logic [NUM_M*LEN_W-1:0]  arlen_m_i,
  output logic [NUM_M-1:0]        arready_m_o,
  output logic                    arvalid_o,
  output logic [ADDR_W-1:0]       araddr_o,
  output logic [LEN_W-1:0]        arlen_o,
  input  logic                    arready_i,
  input  logic                    rvalid_i,
  input  logic                    rready_i,
  input  logic                    rlast_i,
  output logic [NUM_M-1:0]        grant_o,
  output logic [IDX_W-1:0]        grant_idx_o,
  output logic                    busy_o
`ifdef AXI_RD_ARB_TIMEOUT_EN
  ,
  output logic                    timeout_o
`endif
);

  // Elaboration-time sanity check of the configuration.
  if (IDX_W < $clog2(NUM_M) || TIMEOUT_CYC < 2) begin : g_bad_cfg
    $error("axi_rd_arbiter: IDX_W too narrow or TIMEOUT_CYC below 2");
  end

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2
  } state_t;

  state_t              state_r;
  state_t              state_nxt_s;

  logic [NUM_M-1:0]    grant_r;
  logic [IDX_W-1:0]    grant_idx_r;
  logic [IDX_W-1:0]    last_r;
  logic                busy_r;

  logic                pick_vld_s;
  logic [IDX_W-1:0]    pick_idx_s;
  logic [NUM_M-1:0]    pick_oh_s;

  logic                sel_vld_s;
  logic [ADDR_W-1:0]   sel_addr_s;
  logic [LEN_W-1:0]    sel_len_s;

  logic                ar_hs_s;
  logic                r_last_hs_s;
  logic                timeout_s;

  // Round-robin pick: first requester after last_r, wrapping NUM_M-1 -> 0.
  always_comb begin
    pick_vld_s = 1'b0;
    pick_idx_s = '0;
    for (int off = 1; off <= NUM_M; off++) begin
      for (int k = 0; k < NUM_M; k++) begin
        if (!pick_vld_s && arvalid_m_i[k] &&
            (((int'(last_r) + off) % NUM_M) == k)) begin
          pick_vld_s = 1'b1;
          pick_idx_s = IDX_W'(k);
        end else begin
          pick_vld_s = pick_vld_s;
        end
      end
    end
  end

  // One-hot form of the winning index, loaded into the grant register.
  always_comb begin
    pick_oh_s = '0;
    for (int k = 0; k < NUM_M; k++) begin
      if (pick_idx_s == IDX_W'(k)) begin
        pick_oh_s[k] = 1'b1;
      end else begin
        pick_oh_s[k] = 1'b0;
      end
    end
  end

  // Select the granted master's request fields from the packed buses.
  always_comb begin
    sel_vld_s  = 1'b0;
    sel_addr_s = '0;
    sel_len_s  = '0;
    for (int k = 0; k < NUM_M; k++) begin
      if (grant_idx_r == IDX_W'(k)) begin
        sel_vld_s  = arvalid_m_i[k];
        sel_addr_s = araddr_m_i[k*ADDR_W +: ADDR_W];
        sel_len_s  = arlen_m_i[k*LEN_W +: LEN_W];
      end else begin
        sel_vld_s  = sel_vld_s;
      end
    end
  end

  // Address handshake only counts in ADDR; R beats only count in DATA.
  assign ar_hs_s     = (state_r == ST_ADDR) & sel_vld_s & arready_i;
  assign r_last_hs_s = (state_r == ST_DATA) & rvalid_i & rready_i & rlast_i;

`ifdef AXI_RD_ARB_TIMEOUT_EN
  logic [15:0] wd_cnt_r;

  // Watchdog: count DATA cycles that pass without the closing R beat.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      wd_cnt_r <= 16'd0;
    end else if (ar_hs_s) begin
      wd_cnt_r <= 16'd0;
    end else if ((state_r == ST_DATA) && !r_last_hs_s && !timeout_s) begin
      wd_cnt_r <= wd_cnt_r + 16'd1;
    end else begin
      wd_cnt_r <= wd_cnt_r;
    end
  end

  // A last-beat handshake on the limit cycle wins over the timeout.
  assign timeout_s = (state_r == ST_DATA) && !r_last_hs_s &&
                     (wd_cnt_r == 16'(TIMEOUT_CYC - 1));
  assign timeout_o = timeout_s;
`else
  assign timeout_s = 1'b0;
`endif

  // State register.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (pick_vld_s) begin
          state_nxt_s = ST_ADDR;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_ADDR: begin
        if (ar_hs_s) begin
          state_nxt_s = ST_DATA;
        end else begin
          state_nxt_s = ST_ADDR;
        end
      end
      ST_DATA: begin
        if (r_last_hs_s || timeout_s) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_DATA;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // Decoder-side outputs and per-master ready, decoded from the state.
  always_comb begin
    arvalid_o   = 1'b0;
    araddr_o    = '0;
    arlen_o     = '0;
    arready_m_o = '0;
    case (state_r)
      ST_ADDR: begin
        arvalid_o = sel_vld_s;
        araddr_o  = sel_addr_s;
        arlen_o   = sel_len_s;
        if (arready_i) begin
          arready_m_o = grant_r;
        end else begin
          arready_m_o = '0;
        end
      end
      ST_DATA: begin
        araddr_o = sel_addr_s;
        arlen_o  = sel_len_s;
      end
      default: begin
        arvalid_o = 1'b0;
      end
    endcase
  end

  // Grant, round-robin pointer and busy flag registers.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      grant_r     <= '0;
      grant_idx_r <= '0;
      last_r      <= IDX_W'(NUM_M - 1);
      busy_r      <= 1'b0;
    end else begin
      busy_r <= (state_nxt_s != ST_IDLE);
      if ((state_r == ST_IDLE) && pick_vld_s) begin
        grant_r     <= pick_oh_s;
        grant_idx_r <= pick_idx_s;
      end else if ((state_r == ST_DATA) && (r_last_hs_s || timeout_s)) begin
        grant_r     <= '0;
      end else begin
        grant_r     <= grant_r;
      end
      if (ar_hs_s || timeout_s) begin
        last_r <= grant_idx_r;
      end else begin
        last_r <= last_r;
      end
    end
  end

  assign grant_o     = grant_r;
  assign grant_idx_o = grant_idx_r;
  assign busy_o      = busy_r;

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// tb_axi_rd_arbiter
// Directed and randomized checks of axi_rd_arbiter against a queue-based
// priority model. Define AXI_RD_ARB_TIMEOUT_EN to include the watchdog case.
`timescale 1ns/1ps
module tb_axi_rd_arbiter;
  localparam int NUM_M  = 3;
  localparam int IDX_W  = 2;
  localparam int ADDR_W = 32;
  localparam int LEN_W  = 4;
  localparam int TO_CYC = 16;

  logic                    ACLK = 1'b0;
  logic                    ARESETn = 1'b0;
  logic [NUM_M-1:0]        arvalid_m_i;
  logic [NUM_M*ADDR_W-1:0] araddr_m_i;
  logic [NUM_M*LEN_W-1:0]  arlen_m_i;
  logic [NUM_M-1:0]        arready_m_o;
  logic                    arvalid_o;
  logic [ADDR_W-1:0]       araddr_o;
  logic [LEN_W-1:0]        arlen_o;
  logic                    arready_i;
  logic                    rvalid_i;
  logic                    rready_i;
  logic                    rlast_i;
  logic [NUM_M-1:0]        grant_o;
  logic [IDX_W-1:0]        grant_idx_o;
  logic                    busy_o;
`ifdef AXI_RD_ARB_TIMEOUT_EN
  logic                    timeout_o;
`endif

  int checks = 0;
  int errors = 0;

  // Bench-side master state and the priority model.
  logic [NUM_M-1:0]  req;
  logic [ADDR_W-1:0] m_addr [NUM_M];
  logic [LEN_W-1:0]  m_len  [NUM_M];
  int                order[$];
  int                seen_idx;

  axi_rd_arbiter #(
    .NUM_M(NUM_M), .IDX_W(IDX_W), .ADDR_W(ADDR_W), .LEN_W(LEN_W),
    .TIMEOUT_CYC(TO_CYC)
  ) dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .arvalid_m_i(arvalid_m_i), .araddr_m_i(araddr_m_i), .arlen_m_i(arlen_m_i),
    .arready_m_o(arready_m_o), .arvalid_o(arvalid_o), .araddr_o(araddr_o),
    .arlen_o(arlen_o), .arready_i(arready_i), .rvalid_i(rvalid_i),
    .rready_i(rready_i), .rlast_i(rlast_i), .grant_o(grant_o),
    .grant_idx_o(grant_idx_o), .busy_o(busy_o)
`ifdef AXI_RD_ARB_TIMEOUT_EN
    , .timeout_o(timeout_o)
`endif
  );

  always #5 ACLK = ~ACLK;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge ACLK);
    @(negedge ACLK);
  endtask

  task automatic drive_req();
    arvalid_m_i = req;
    for (int k = 0; k < NUM_M; k++) begin
      araddr_m_i[k*ADDR_W +: ADDR_W] = m_addr[k];
      arlen_m_i[k*LEN_W +: LEN_W]    = m_len[k];
    end
  endtask

  task automatic raise(input int k);
    if (!req[k]) begin
      req[k]    = 1'b1;
      m_addr[k] = $urandom;
      m_len[k]  = LEN_W'($urandom_range(0, 3));
    end
  endtask

  // Priority list: head is most favoured; the served master moves to the tail.
  function automatic int model_pick();
    foreach (order[i]) if (req[order[i]]) return order[i];
    return -1;
  endfunction

  task automatic model_commit(input int w);
    while (order[order.size()-1] != w) order.push_back(order.pop_front());
  endtask

  // One full transaction from IDLE: grant, AR backpressure, R beats, release.
  task automatic run_txn(input int ard, input int stall_beat,
                         input logic [NUM_M-1:0] late_req, input bit rnd);
    int                exp;
    int                beats;
    logic [NUM_M-1:0]  g;
    logic [ADDR_W-1:0] a_exp;
    logic [LEN_W-1:0]  l_exp;
    exp   = model_pick();
    g     = NUM_M'(1) << exp;
    a_exp = m_addr[exp];
    l_exp = m_len[exp];
    beats = int'(l_exp) + 1;
    #1;
    chk("idle_arvalid", arvalid_o, 1'b0);
    chk("idle_busy", busy_o, 1'b0);
    step();
    seen_idx = int'(grant_idx_o);
    chk("grant", grant_o, g);
    chk("grant_idx", grant_idx_o, exp);
    chk("arvalid", arvalid_o, 1'b1);
    chk("araddr", araddr_o, a_exp);
    chk("arlen", arlen_o, l_exp);
    chk("busy_addr", busy_o, 1'b1);
    for (int i = 0; i < ard; i++) begin
      arready_i = 1'b0;
      rvalid_i  = 1'b1;
      rready_i  = 1'b1;
      rlast_i   = rnd ? 1'($urandom) : 1'b1;
      #1;
      chk("bp_arready_m", arready_m_o, '0);
      chk("bp_arvalid", arvalid_o, 1'b1);
      chk("bp_araddr", araddr_o, a_exp);
      chk("bp_grant", grant_o, g);
      step();
    end
    rvalid_i  = 1'b0;
    rlast_i   = 1'b0;
    arready_i = 1'b1;
    #1;
    chk("arready_m", arready_m_o, g);
    step();
    arready_i = 1'b0;
    #1;
    chk("data_arready_m", arready_m_o, '0);
    chk("data_arvalid", arvalid_o, 1'b0);
    chk("data_araddr", araddr_o, a_exp);
    req[exp] = 1'b0;
    model_commit(exp);
    for (int k = 0; k < NUM_M; k++) if (late_req[k]) raise(k);
    drive_req();
    for (int b = 0; b < beats; b++) begin
      if (b == stall_beat || (rnd && $urandom_range(0, 2) == 0)) begin
        rvalid_i = 1'b1;
        rready_i = 1'b0;
        rlast_i  = (b == beats - 1);
        step();
        chk("stall_grant", grant_o, g);
        chk("stall_busy", busy_o, 1'b1);
      end
      rvalid_i = 1'b1;
      rready_i = 1'b1;
      rlast_i  = (b == beats - 1);
      step();
      if (b == beats - 1) begin
        chk("end_grant", grant_o, '0);
        chk("end_busy", busy_o, 1'b0);
      end else begin
        chk("beat_grant", grant_o, g);
        chk("beat_busy", busy_o, 1'b1);
      end
    end
    rvalid_i = 1'b0;
    rready_i = 1'b0;
    rlast_i  = 1'b0;
  endtask

  initial begin
    arready_i = 1'b0; rvalid_i = 1'b0; rready_i = 1'b0; rlast_i = 1'b0;
    req = '0;
    for (int k = 0; k < NUM_M; k++) begin m_addr[k] = '0; m_len[k] = '0; end
    drive_req();
    order = {0, 1, 2};

    // Reset values.
    #12;
    chk("rst_grant", grant_o, '0);
    chk("rst_grant_idx", grant_idx_o, '0);
    chk("rst_busy", busy_o, 1'b0);
    chk("rst_arvalid", arvalid_o, 1'b0);
    chk("rst_arready_m", arready_m_o, '0);
    @(negedge ACLK);
    ARESETn = 1'b1;

    // Single request from M1.
    m_addr[1] = 32'h0001_0040;
    m_len[1]  = 4'd0;
    req       = 3'b010;
    drive_req();
    run_txn(0, -1, 3'b000, 1'b0);
    chk("single_idx", seen_idx, 1);

    // Decoder backpressure for five cycles on M2.
    raise(2);
    drive_req();
    run_txn(5, -1, 3'b000, 1'b0);
    chk("bp_idx", seen_idx, 2);

    // Burst lock: M0 len 3 with a stall on beat 2, M2 asks during DATA.
    req       = 3'b001;
    m_addr[0] = 32'hA000_0100;
    m_len[0]  = 4'd3;
    drive_req();
    run_txn(0, 1, 3'b100, 1'b0);
    chk("lock_idx", seen_idx, 0);
    run_txn(0, -1, 3'b000, 1'b0);
    chk("after_lock_idx", seen_idx, 2);

    // Reset in the middle of a burst.
    req       = 3'b001;
    m_addr[0] = 32'h0000_2000;
    drive_req();
    step();
    arready_i = 1'b1;
    step();
    arready_i = 1'b0;
    req = '0;
    drive_req();
    #1;
    chk("mid_busy_before", busy_o, 1'b1);
    ARESETn = 1'b0;
    #1;
    chk("mid_rst_grant", grant_o, '0);
    chk("mid_rst_busy", busy_o, 1'b0);
    order = {0, 1, 2};
    @(negedge ACLK);
    ARESETn = 1'b1;
    raise(1);
    raise(2);
    drive_req();
    run_txn(0, -1, 3'b000, 1'b0);
    chk("post_rst_idx", seen_idx, 1);

    // Fairness from reset: all masters request continuously with len 0.
    ARESETn = 1'b0;
    req = '0;
    drive_req();
    order = {0, 1, 2};
    @(negedge ACLK);
    ARESETn = 1'b1;
    for (int i = 0; i < 6; i++) begin
      for (int k = 0; k < NUM_M; k++) begin
        if (!req[k]) begin
          req[k] = 1'b1; m_len[k] = 4'd0; m_addr[k] = $urandom;
        end
      end
      drive_req();
      run_txn(0, -1, 3'b000, 1'b0);
      chk("fair_order", seen_idx, i % NUM_M);
    end

`ifdef AXI_RD_ARB_TIMEOUT_EN
    // Watchdog: no R beats after the address handshake.
    begin
      int w;
      raise(0); raise(1); raise(2);
      drive_req();
      w = model_pick();
      step();
      chk("to_grant_idx", grant_idx_o, w);
      arready_i = 1'b1;
      step();
      arready_i = 1'b0;
      req[w] = 1'b0;
      model_commit(w);
      raise(w);
      drive_req();
      for (int c = 1; c <= TO_CYC; c++) begin
        #1;
        chk("to_pulse", timeout_o, (c == TO_CYC));
        step();
      end
      chk("to_busy", busy_o, 1'b0);
      chk("to_grant", grant_o, '0);
      run_txn(0, -1, 3'b000, 1'b0);
      chk("to_next_idx", seen_idx, (w + 1) % NUM_M);
    end
`endif

    // Randomized traffic against the priority model.
    for (int t = 0; t < 40; t++) begin
      if (req == '0) begin
        for (int k = 0; k < NUM_M; k++) if ($urandom_range(0, 1) == 1) raise(k);
        if (req == '0) raise($urandom_range(0, NUM_M - 1));
      end
      drive_req();
      run_txn($urandom_range(0, 3), -1, NUM_M'($urandom), 1'b1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
